// File: rtl/regfile_mp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_pkg
// Purpose  : Shared constants and clear-sequencer state encoding for the
//            multi-port integer register file.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_mp_pkg;

  localparam int XLEN     = 32;
  localparam int NREGS    = 32;
  localparam int RS_WIDTH = $clog2(NREGS);

  // Clear sequencer: INIT zeroes storage after reset, RUN is terminal.
  typedef enum logic [0:0] {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_if
// Purpose  : Read/write/scoreboard bus of the multi-port register file.
//            master = pipeline side, slave = register file.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_mp_if #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2
);
  localparam int AW = $clog2(NREGS);

  logic                   init_done;
  logic [NREAD*AW-1:0]    rd_addr;
  logic [NREAD*XLEN-1:0]  rd_data;
  logic [NREAD-1:0]       rd_busy;
  logic [NWRITE-1:0]      wr_en;
  logic [NWRITE*AW-1:0]   wr_addr;
  logic [NWRITE*XLEN-1:0] wr_data;
  logic                   bsy_set;
  logic [AW-1:0]          bsy_addr;
  logic                   flush;

  modport master (
    input  init_done, rd_data, rd_busy,
    output rd_addr, wr_en, wr_addr, wr_data, bsy_set, bsy_addr, flush
  );

  modport slave (
    output init_done, rd_data, rd_busy,
    input  rd_addr, wr_en, wr_addr, wr_data, bsy_set, bsy_addr, flush
  );

endinterface
`default_nettype wire

// File: rtl/regfile_mp_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_scoreboard
// Purpose  : Per-register busy bits with flush > set > write-clear priority,
//            and per-read-port busy lookup unblocked by same-cycle writeback.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int NREGS  = regfile_mp_pkg::NREGS,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 bsy_set,
  input  logic [AW-1:0]        bsy_addr,
  input  logic                 flush,
  input  logic [NWRITE-1:0]    wr_en,
  input  logic [NWRITE*AW-1:0] wr_addr,
  input  logic [NREAD*AW-1:0]  rd_addr,
  output logic [NREAD-1:0]     rd_busy
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  // Next busy vector: write clears first, a new issue overrides, flush wipes all.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      for (int k = 0; k < NWRITE; k++) begin
        if (wr_en[k]) busy_nxt[wr_addr[k*AW +: AW]] = 1'b0;
      end
      if (bsy_set) busy_nxt[bsy_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Busy register; only updated once the clear sequence has finished.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else if (run) begin
      busy <= busy_nxt;
    end
  end

  // Reader sees busy unless a writer to the same register lands this cycle.
  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NREAD; i++) begin
      rd_busy[i] = run && busy[rd_addr[i*AW +: AW]];
      for (int k = 0; k < NWRITE; k++) begin
        if (wr_en[k] && (wr_addr[k*AW +: AW] == rd_addr[i*AW +: AW])) rd_busy[i] = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : N-read / 1..2-write integer register file with write-to-read
//            bypass, busy scoreboard and a post-reset clear sequencer so the
//            storage needs no per-entry reset.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN   = regfile_mp_pkg::XLEN,
  parameter int NREGS  = regfile_mp_pkg::NREGS,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2
) (
  input  logic          clk,
  input  logic          rst,
  regfile_mp_if.slave   bus
);

  localparam int AW = $clog2(NREGS);

  rf_state_t        state;
  rf_state_t        state_nxt;
  logic [AW-1:0]    ptr;
  logic [AW-1:0]    ptr_nxt;
  logic             clr_en;
  logic             run;
  logic             init_done_q;
  logic [XLEN-1:0]  mem [NREGS];

  assign run           = (state == RF_RUN);
  assign bus.init_done = init_done_q;

  // Sequencer registers; init_done trails the move to RUN by one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RF_INIT;
      ptr         <= AW'(1);
      init_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      init_done_q <= (state == RF_RUN);
    end
  end

  // Clear walk over entries 1..NREGS-1; x0 is never stored.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    clr_en    = 1'b0;
    case (state)
      RF_INIT: begin
        clr_en = 1'b1;
        if (ptr == AW'(NREGS - 1)) state_nxt = RF_RUN;
        else                       ptr_nxt   = ptr + AW'(1);
      end
      RF_RUN:  state_nxt = RF_RUN;
      default: state_nxt = RF_INIT;
    endcase
  end

  // Storage without reset so it can map to RAM; later write port wins.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[ptr] <= '0;
    end else if (run) begin
      for (int k = 0; k < NWRITE; k++) begin
        if (bus.wr_en[k] && (bus.wr_addr[k*AW +: AW] != '0))
          mem[bus.wr_addr[k*AW +: AW]] <= bus.wr_data[k*XLEN +: XLEN];
      end
    end
  end

  // Zero-latency reads: x0 and INIT force 0, highest write port bypasses.
  always_comb begin
    bus.rd_data = '0;
    for (int i = 0; i < NREAD; i++) begin
      bus.rd_data[i*XLEN +: XLEN] = mem[bus.rd_addr[i*AW +: AW]];
      for (int k = 0; k < NWRITE; k++) begin
        if (bus.wr_en[k] && (bus.wr_addr[k*AW +: AW] == bus.rd_addr[i*AW +: AW]))
          bus.rd_data[i*XLEN +: XLEN] = bus.wr_data[k*XLEN +: XLEN];
      end
      if (!run || (bus.rd_addr[i*AW +: AW] == '0))
        bus.rd_data[i*XLEN +: XLEN] = '0;
    end
  end

  regfile_mp_scoreboard #(
    .NREGS  (NREGS),
    .NREAD  (NREAD),
    .NWRITE (NWRITE),
    .AW     (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .bsy_set  (bus.bsy_set),
    .bsy_addr (bus.bsy_addr),
    .flush    (bus.flush),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .rd_addr  (bus.rd_addr),
    .rd_busy  (bus.rd_busy)
  );

endmodule
`default_nettype wire
